// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the multi-FIFO flow-control controller: state
// encoding, widths and the per-channel FIFO misuse rule.
package flow_ctrl_pkg;

    localparam int STATE_W      = 3;
    localparam int TH_WIDTH_DEF = 4;
    localparam int ERR_CNT_W    = 8;

    typedef enum logic [STATE_W-1:0] {
        RESET  = 3'd0,
        INIT   = 3'd1,
        IDLE   = 3'd2,
        ACTIVE = 3'd3,
        ERROR  = 3'd4
    } state_e;

    // A FIFO is misused when it claims full and empty at once, is written
    // while full without a compensating read, or is read while empty
    // without a compensating write.
    function automatic logic fifo_misuse(input logic full, input logic empty,
                                         input logic wr, input logic rd);
        return (full & empty) | (full & wr & ~rd) | (empty & rd & ~wr);
    endfunction

    // States in which channel errors accumulate into the sticky mask.
    function automatic logic is_supervised(input state_e s);
        return (s == IDLE) || (s == ACTIVE) || (s == ERROR);
    endfunction

endpackage

// File: rtl/fifo_err_chk.sv
// Combinational error detector for one supervised FIFO channel.
module fifo_err_chk
    import flow_ctrl_pkg::*;
(
    input  logic full,
    input  logic empty,
    input  logic wr,
    input  logic rd,
    output logic err
);

    assign err = fifo_misuse(full, empty, wr, rd);

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Multi-FIFO flow-control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) with threshold
// latching and sticky per-channel error mask. Define FLOW_CTRL_ERR_CNT_EN to add err_cnt.
module flow_ctrl_fsm
    import flow_ctrl_pkg::*;
#(
    parameter int NUM_FIFOS = 4,
    parameter int TH_WIDTH  = TH_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init_req,
    input  logic [TH_WIDTH-1:0]  umbral_mf_in,
    input  logic [TH_WIDTH-1:0]  umbral_vc_in,
    input  logic [TH_WIDTH-1:0]  umbral_d_in,
    input  logic [NUM_FIFOS-1:0] fifo_full,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [NUM_FIFOS-1:0] fifo_wr,
    input  logic [NUM_FIFOS-1:0] fifo_rd,
    output logic [TH_WIDTH-1:0]  umbral_mf_out,
    output logic [TH_WIDTH-1:0]  umbral_vc_out,
    output logic [TH_WIDTH-1:0]  umbral_d_out,
    output logic                 init_out,
    output logic                 idle_out,
    output logic                 active_out,
    output logic                 error_out,
    output logic [NUM_FIFOS-1:0] error_ch,
    output logic [STATE_W-1:0]   state,
    output logic [STATE_W-1:0]   next_state
`ifdef FLOW_CTRL_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    state_e               state_r;
    state_e               next_state_s;
    logic [NUM_FIFOS-1:0] err_s;
    logic                 any_err_s;
    logic                 all_empty_s;
    logic                 th_nonzero_s;
    logic [TH_WIDTH-1:0]  umbral_mf_r;
    logic [TH_WIDTH-1:0]  umbral_vc_r;
    logic [TH_WIDTH-1:0]  umbral_d_r;
    logic [NUM_FIFOS-1:0] error_ch_r;
    logic                 init_r;
    logic                 idle_r;
    logic                 active_r;
    logic                 error_r;

    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_chk
        fifo_err_chk u_fifo_err_chk (
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .wr    (fifo_wr[g]),
            .rd    (fifo_rd[g]),
            .err   (err_s[g])
        );
    end

    assign any_err_s    = |err_s;
    assign all_empty_s  = &fifo_empty;
    assign th_nonzero_s = (|umbral_mf_r) | (|umbral_vc_r) | (|umbral_d_r);

    // Next-state decision: error beats init_req, init_req beats data activity.
    always_comb begin
        next_state_s = RESET;
        case (state_r)
            RESET: begin
                next_state_s = INIT;
            end
            INIT: begin
                if (init_req) begin
                    next_state_s = INIT;
                end else if (th_nonzero_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = INIT;
                end
            end
            IDLE: begin
                if (any_err_s) begin
                    next_state_s = ERROR;
                end else if (init_req) begin
                    next_state_s = INIT;
                end else if (!all_empty_s) begin
                    next_state_s = ACTIVE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (any_err_s) begin
                    next_state_s = ERROR;
                end else if (init_req) begin
                    next_state_s = INIT;
                end else if (all_empty_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ACTIVE;
                end
            end
            ERROR: begin
                if (any_err_s) begin
                    next_state_s = ERROR;
                end else begin
                    next_state_s = RESET;
                end
            end
            default: begin
                next_state_s = RESET;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Threshold capture; values survive ERROR and RESET, only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            umbral_mf_r <= {TH_WIDTH{1'b0}};
            umbral_vc_r <= {TH_WIDTH{1'b0}};
            umbral_d_r  <= {TH_WIDTH{1'b0}};
        end else if ((state_r == INIT) && init_req) begin
            umbral_mf_r <= umbral_mf_in;
            umbral_vc_r <= umbral_vc_in;
            umbral_d_r  <= umbral_d_in;
        end else begin
            umbral_mf_r <= umbral_mf_r;
            umbral_vc_r <= umbral_vc_r;
            umbral_d_r  <= umbral_d_r;
        end
    end

    // Sticky per-channel error mask, cleared by the RESET state.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_ch_r <= {NUM_FIFOS{1'b0}};
        end else if (state_r == RESET) begin
            error_ch_r <= {NUM_FIFOS{1'b0}};
        end else if (is_supervised(state_r)) begin
            error_ch_r <= error_ch_r | err_s;
        end else begin
            error_ch_r <= error_ch_r;
        end
    end

    // Status flags registered from next_state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_r   <= 1'b0;
            idle_r   <= 1'b0;
            active_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            init_r   <= (next_state_s == INIT);
            idle_r   <= (next_state_s == IDLE);
            active_r <= (next_state_s == ACTIVE);
            error_r  <= (next_state_s == ERROR);
        end
    end

`ifdef FLOW_CTRL_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Saturating count of entries into ERROR; the RESET state leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if ((next_state_s == ERROR) && (state_r != ERROR) &&
                     (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

    assign umbral_mf_out = umbral_mf_r;
    assign umbral_vc_out = umbral_vc_r;
    assign umbral_d_out  = umbral_d_r;
    assign error_ch      = error_ch_r;
    assign init_out      = init_r;
    assign idle_out      = idle_r;
    assign active_out    = active_r;
    assign error_out     = error_r;
    assign state         = state_r;
    assign next_state    = next_state_s;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Self-checking bench for flow_ctrl_fsm: directed test-plan steps followed by
// randomized traffic compared against a behavioural model of the controller.
module tb_flow_ctrl_fsm;

    localparam int NF = 4;
    localparam int TW = 4;
    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_req;
    logic [TW-1:0] umbral_mf_in, umbral_vc_in, umbral_d_in;
    logic [NF-1:0] fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic [TW-1:0] umbral_mf_out, umbral_vc_out, umbral_d_out;
    logic          init_out, idle_out, active_out, error_out;
    logic [NF-1:0] error_ch;
    logic [2:0]    state, next_state;
`ifdef FLOW_CTRL_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    int            m_state;
    logic [TW-1:0] m_mf, m_vc, m_d;
    logic [NF-1:0] m_ech;
    int            m_cnt;

    always #5 clk = ~clk;

    flow_ctrl_fsm #(.NUM_FIFOS(NF), .TH_WIDTH(TW)) dut (
        .clk           (clk),
        .reset         (reset),
        .init_req      (init_req),
        .umbral_mf_in  (umbral_mf_in),
        .umbral_vc_in  (umbral_vc_in),
        .umbral_d_in   (umbral_d_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_wr       (fifo_wr),
        .fifo_rd       (fifo_rd),
        .umbral_mf_out (umbral_mf_out),
        .umbral_vc_out (umbral_vc_out),
        .umbral_d_out  (umbral_d_out),
        .init_out      (init_out),
        .idle_out      (idle_out),
        .active_out    (active_out),
        .error_out     (error_out),
        .error_ch      (error_ch),
        .state         (state),
        .next_state    (next_state)
`ifdef FLOW_CTRL_ERR_CNT_EN
        ,
        .err_cnt       (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("state",      32'(state),         32'(m_state));
        check("init_out",   32'(init_out),      32'(m_state == M_INIT));
        check("idle_out",   32'(idle_out),      32'(m_state == M_IDLE));
        check("active_out", 32'(active_out),    32'(m_state == M_ACTIVE));
        check("error_out",  32'(error_out),     32'(m_state == M_ERROR));
        check("umbral_mf",  32'(umbral_mf_out), 32'(m_mf));
        check("umbral_vc",  32'(umbral_vc_out), 32'(m_vc));
        check("umbral_d",   32'(umbral_d_out),  32'(m_d));
        check("error_ch",   32'(error_ch),      32'(m_ech));
`ifdef FLOW_CTRL_ERR_CNT_EN
        check("err_cnt",    32'(err_cnt),       32'(m_cnt));
`endif
    endtask

    // Apply the current inputs for one clock, advance the model, compare.
    task automatic cycle();
        logic [NF-1:0] e;
        bit any_err, all_empty, th_nz;
        int nxt;
        #1;
        for (int i = 0; i < NF; i++) begin
            e[i] = (fifo_full[i] && fifo_empty[i]) ||
                   (fifo_full[i] && fifo_wr[i] && !fifo_rd[i]) ||
                   (fifo_empty[i] && fifo_rd[i] && !fifo_wr[i]);
        end
        any_err   = (e != '0);
        all_empty = (fifo_empty == '1);
        th_nz     = (m_mf != 0) || (m_vc != 0) || (m_d != 0);
        if (m_state == M_RESET)                           nxt = M_INIT;
        else if (m_state == M_INIT)                       nxt = (!init_req && th_nz) ? M_IDLE : M_INIT;
        else if (m_state == M_ERROR)                      nxt = any_err ? M_ERROR : M_RESET;
        else if (any_err)                                 nxt = M_ERROR;
        else if (init_req)                                nxt = M_INIT;
        else if (all_empty)                               nxt = M_IDLE;
        else                                              nxt = M_ACTIVE;
        if (!reset) check("next_state", 32'(next_state), 32'(nxt));
        @(posedge clk);
        if (reset) begin
            m_state = M_RESET; m_mf = '0; m_vc = '0; m_d = '0; m_ech = '0; m_cnt = 0;
        end else begin
            if (m_state == M_INIT && init_req) begin
                m_mf = umbral_mf_in; m_vc = umbral_vc_in; m_d = umbral_d_in;
            end
            if (m_state == M_RESET) m_ech = '0;
            else if (m_state >= M_IDLE) m_ech = m_ech | e;
            if (nxt == M_ERROR && m_state != M_ERROR && m_cnt < 255) m_cnt++;
            m_state = nxt;
        end
        #1;
        compare_all();
    endtask

    task automatic clean_inputs();
        init_req = 1'b0;
        fifo_full = '0; fifo_empty = '1; fifo_wr = '0; fifo_rd = '0;
    endtask

    // Walk the controller into IDLE with a nonzero threshold, bounded.
    task automatic reach_idle();
        int n = 0;
        clean_inputs();
        while (m_state != M_IDLE && n < 20) begin
            init_req = (m_state == M_INIT && m_mf == 0);
            umbral_mf_in = 4'h3;
            cycle();
            n++;
        end
        init_req = 1'b0;
        check("reach_idle", 32'(state), 32'(M_IDLE));
    endtask

    initial begin
        reset = 1'b1;
        umbral_mf_in = '0; umbral_vc_in = '0; umbral_d_in = '0;
        clean_inputs();
        m_state = M_RESET; m_mf = '0; m_vc = '0; m_d = '0; m_ech = '0; m_cnt = 0;
        cycle(); cycle();
        check("reset_state", 32'(state), 32'(0));
        check("reset_flags", 32'({init_out, idle_out, active_out, error_out}), 32'(0));

        // Thresholds stay zero: INIT must hold indefinitely
        reset = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        check("zero_th_init_out", 32'(init_out), 32'(1));
        check("zero_th_state", 32'(state), 32'(M_INIT));

        // Load mf=3 for two cycles, then release -> IDLE
        init_req = 1'b1; umbral_mf_in = 4'h3; umbral_vc_in = 4'h0; umbral_d_in = 4'h0;
        cycle(); cycle();
        init_req = 1'b0; umbral_mf_in = 4'h0;
        cycle();
        check("plan_idle_out", 32'(idle_out), 32'(1));
        check("plan_mf", 32'(umbral_mf_out), 32'(3));

        // IDLE <-> ACTIVE on data presence
        fifo_empty = 4'b1011; cycle();
        check("plan_active_out", 32'(active_out), 32'(1));
        fifo_empty = 4'b1111; cycle();
        check("plan_back_idle", 32'(state), 32'(M_IDLE));

        // Overflow write on channel 2 while ACTIVE
        fifo_empty = 4'b1011; cycle();
        fifo_full = 4'b0100; fifo_wr = 4'b0100; fifo_rd = 4'b0000; cycle();
        check("plan_err_ch", 32'(error_ch), 32'(4'b0100));
        check("plan_error_out", 32'(error_out), 32'(1));
        fifo_full = '0; fifo_wr = '0; cycle();
        check("plan_to_reset", 32'(state), 32'(M_RESET));
        cycle();
        check("plan_to_init", 32'(state), 32'(M_INIT));
        check("plan_err_ch_clr", 32'(error_ch), 32'(0));
        check("plan_th_kept", 32'(umbral_mf_out), 32'(3));

        // Error wins over simultaneous init_req
        cycle();
        fifo_empty = 4'b1011; cycle();
        init_req = 1'b1; fifo_full = 4'b0001; cycle();
        check("plan_err_priority", 32'(state), 32'(M_ERROR));
        clean_inputs(); cycle(); cycle();

`ifdef FLOW_CTRL_ERR_CNT_EN
        // Three fresh error episodes after a hard reset
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            reach_idle();
            fifo_full = 4'b1000; fifo_empty = 4'b1111; cycle();
            clean_inputs(); cycle();
        end
        check("plan_err_cnt3", 32'(err_cnt), 32'(3));
        reach_idle();
        fifo_full = 4'b0010; cycle();
        reset = 1'b1; cycle();
        check("plan_reset_mid_error", 32'(state), 32'(M_RESET));
        check("plan_err_cnt0", 32'(err_cnt), 32'(0));
        reset = 1'b0; clean_inputs(); cycle();
`endif

        // Randomized traffic with occasional errors, reloads and resets
        for (int n = 0; n < 600; n++) begin
            reset        = ($urandom_range(0, 63) == 0);
            init_req     = ($urandom_range(0, 9) == 0);
            umbral_mf_in = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            umbral_vc_in = 4'($urandom);
            umbral_d_in  = 4'($urandom);
            fifo_empty   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            fifo_wr      = 4'($urandom);
            fifo_rd      = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                fifo_full = 4'($urandom & $urandom);
            end else begin
                fifo_full = '0;
                fifo_rd   = fifo_rd & ~fifo_empty;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
